mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-stage consumer of the Execute→Memory pipeline register.
- Takes one instruction bundle per handshake: opcode, funct, dstE, dstM, valE (ALU result/address), valA (store data), pc, stat.
- For loads and stores, drives a split address/data bus transaction. Otherwise forwards the bundle unchanged.
- Presents the Memory→Writeback bundle with a loaded value valM under valid/ready.

Parameters:
OP_LW, 6'h23, opcode treated as word load
OP_SW, 6'h2b, opcode treated as word store
ADDR_W, 32, address and data width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  squash current instruction (exception/redirect)
in_valid  in  1  upstream bundle valid
in_ready  out  1  stage can accept bundle
in_opcode  in  6  opcode
in_funct  in  6  funct
in_dstE  in  5  ALU-result destination register
in_dstM  in  5  load destination register
in_valE  in  ADDR_W  ALU result / effective address
in_valA  in  ADDR_W  store data
in_pc  in  ADDR_W  instruction pc
in_stat  in  2  0=AOK, 1=ADEL, 2=ADES, 3=upstream fault
dreq_valid  out  1  bus request valid
dreq_addr  out  ADDR_W  word-aligned address
dreq_strobe  out  4  byte write enables; 0 = read
dreq_data  out  ADDR_W  write data
dresp_addr_ok  in  1  request accepted
dresp_data_ok  in  1  response complete
dresp_data  in  ADDR_W  read data
out_valid  out  1  writeback bundle valid
out_ready  in  1  writeback accepts
out_dstE, out_dstM  out  5 each  registered copies
out_valE, out_pc  out  ADDR_W  registered copies
out_valM  out  ADDR_W  loaded data (0 for non-loads)
out_stat  out  2  final status

Behaviour:
- Reset: all outputs 0; state IDLE; flush_pending 0. Reset mid-transaction abandons it; the bus side must tolerate this.
- in_ready = 1 only in IDLE, or in DONE while out_ready=1 (back-to-back accept).
- Capture on in_valid && in_ready. All fields are registered; outputs come from registers only.
- Classification at capture:
  - mem op = opcode is OP_LW/OP_SW and in_stat==0.
  - Misaligned mem op (valE[1:0]!=0): no bus access, stat=1 for LW, 2 for SW, go DONE.
  - Non-mem ops go to DONE next cycle (1-cycle latency).
- States:
  - IDLE: nothing held.
  - REQ: dreq_valid=1; addr/strobe/data stable until dresp_addr_ok. Strobe is 4'hF for SW, 0 for LW.
  - REQ exit: addr_ok&&data_ok in the same cycle → DONE; addr_ok only → WAIT.
  - WAIT: dreq_valid=0; on data_ok → DONE.
  - Load data: latch dresp_data into valM on data_ok (loads only).
  - DONE: out_valid=1 and bundle held stable until out_ready.
  - DONE exit: out_ready && in_valid → capture next instruction; out_ready && !in_valid → IDLE.
- Flush:
  - In IDLE: ignored.
  - In DONE: drop the bundle (out_valid deasserts next cycle) → IDLE.
  - In REQ/WAIT: set flush_pending. The transaction still completes (no aborts on bus). On completion go IDLE without out_valid, then clear flush_pending.
  - flush and capture in the same cycle: the flush wins; nothing is captured.
- One outstanding bus transaction maximum; dreq_valid never asserts in WAIT or DONE.
- out_valM is 0 for stores, non-mem ops and faulted ops.

Optional Feature:
MEM_BYTE_HALF_EN:
- Defined:
  - Adds LB(20), LBU(24), LH(21), LHU(25), SB(28), SH(29).
  - Alignment check uses size: byte never faults; half faults on valE[0].
  - Store strobe is shifted by valE[1:0]; store data is replicated per lane.
  - Load result is the selected lane, sign- or zero-extended.
- Undefined: these opcodes are non-mem ops and pass through in 1 cycle with valM=0.

Test Plan:
- ADDIU bundle valE=0x00000005, out_ready=1 → out_valid next cycle, valE=5, valM=0, no dreq_valid.
- LW valE=0x80001000; addr_ok after 2 cycles, data_ok 3 cycles later with data 0xDEADBEEF → dreq held 2 cycles with strobe 0, out_valM=0xDEADBEEF, stat 0.
- SW valE=0x80001004, valA=0x12345678; addr_ok and data_ok in the same cycle → dreq_strobe=4'hF, dreq_data=0x12345678, DONE next cycle.
- LW valE=0x80001002 → no dreq_valid, out_stat=1. SW to the same address → out_stat=2.
- flush asserted in WAIT of an LW → data_ok still consumed, no out_valid, in_ready returns next cycle.
- out_ready held 0 for 4 cycles in DONE → all out_* stable. Then out_ready=1 with in_valid=1 → next bundle accepted in the same cycle.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Execute->Memory bundle, data bus request/response, and Memory->Writeback bundle for mem_access_stage.
// The master modport is the stage itself; the slave modport is its environment (upstream, memory, writeback).
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_opcode;
  logic [5:0]        in_funct;
  logic [4:0]        in_dstE;
  logic [4:0]        in_dstM;
  logic [ADDR_W-1:0] in_valE;
  logic [ADDR_W-1:0] in_valA;
  logic [ADDR_W-1:0] in_pc;
  logic [1:0]        in_stat;

  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [3:0]        dreq_strobe;
  logic [ADDR_W-1:0] dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [ADDR_W-1:0] dresp_data;

  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_dstE;
  logic [4:0]        out_dstM;
  logic [ADDR_W-1:0] out_valE;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_valM;
  logic [1:0]        out_stat;

  modport master (
    input  in_valid, in_opcode, in_funct, in_dstE, in_dstM, in_valE, in_valA, in_pc, in_stat,
    output in_ready,
    output dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    output out_valid, out_dstE, out_dstM, out_valE, out_pc, out_valM, out_stat,
    input  out_ready
  );

  modport slave (
    output in_valid, in_opcode, in_funct, in_dstE, in_dstM, in_valE, in_valA, in_pc, in_stat,
    input  in_ready,
    input  dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    input  out_valid, out_dstE, out_dstM, out_valE, out_pc, out_valM, out_stat,
    output out_ready
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory pipeline stage: issues one split address/data bus transaction per load/store, else forwards the bundle.
// Optional MEM_BYTE_HALF_EN adds byte/halfword loads and stores (LB/LBU/LH/LHU/SB/SH).
module mem_access_stage #(
  parameter logic [5:0]  OP_LW  = 6'h23,
  parameter logic [5:0]  OP_SW  = 6'h2b,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  mem_access_stage_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t state, state_next;
  logic   flush_pending;

  logic [4:0]        r_dstE, r_dstM;
  logic [ADDR_W-1:0] r_valE, r_valA, r_pc, r_valM;
  logic [1:0]        r_stat, r_size;
  logic              r_load, r_store, r_unsigned;

  logic       dec_load, dec_store, dec_unsigned, dec_misaligned, dec_mem_go;
  logic [1:0] dec_size, dec_stat;

  logic in_ready_int, capture, complete, drop;

  always_comb begin
    dec_load     = 1'b0;
    dec_store    = 1'b0;
    dec_unsigned = 1'b0;
    dec_size     = SZ_WORD;
    if (bus.in_stat == 2'd0) begin
      if (bus.in_opcode == OP_LW) begin
        dec_load = 1'b1;
      end else if (bus.in_opcode == OP_SW) begin
        dec_store = 1'b1;
      end
`ifdef MEM_BYTE_HALF_EN
      else begin
        case (bus.in_opcode)
          6'h20: begin dec_load = 1'b1; dec_size = SZ_BYTE; end
          6'h24: begin dec_load = 1'b1; dec_size = SZ_BYTE; dec_unsigned = 1'b1; end
          6'h21: begin dec_load = 1'b1; dec_size = SZ_HALF; end
          6'h25: begin dec_load = 1'b1; dec_size = SZ_HALF; dec_unsigned = 1'b1; end
          6'h28: begin dec_store = 1'b1; dec_size = SZ_BYTE; end
          6'h29: begin dec_store = 1'b1; dec_size = SZ_HALF; end
          default: ;
        endcase
      end
`endif
    end
    dec_misaligned = (dec_load || dec_store) &&
                     (((dec_size == SZ_WORD) && (bus.in_valE[1:0] != 2'b00)) ||
                      ((dec_size == SZ_HALF) && bus.in_valE[0]));
    dec_mem_go = (dec_load || dec_store) && !dec_misaligned;
    dec_stat   = dec_misaligned ? (dec_load ? 2'd1 : 2'd2) : bus.in_stat;
  end

  assign in_ready_int = !reset && ((state == S_IDLE) || ((state == S_DONE) && bus.out_ready));
  // flush beats a same-cycle capture
  assign capture  = bus.in_valid && in_ready_int && !flush;
  assign complete = ((state == S_REQ) && bus.dresp_addr_ok && bus.dresp_data_ok) ||
                    ((state == S_WAIT) && bus.dresp_data_ok);
  assign drop     = flush_pending || flush;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (capture) state_next = dec_mem_go ? S_REQ : S_DONE;
      S_REQ: begin
        if (bus.dresp_addr_ok) begin
          if (bus.dresp_data_ok) state_next = drop ? S_IDLE : S_DONE;
          else                   state_next = S_WAIT;
        end
      end
      S_WAIT: if (bus.dresp_data_ok) state_next = drop ? S_IDLE : S_DONE;
      S_DONE: begin
        if (flush)              state_next = S_IDLE;
        else if (capture)       state_next = dec_mem_go ? S_REQ : S_DONE;
        else if (bus.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = in_ready_int;
    bus.dreq_valid = (state == S_REQ);
    bus.out_valid  = (state == S_DONE);
  end

  logic [ADDR_W-1:0] lane;
  logic [ADDR_W-1:0] load_value;

  assign lane = bus.dresp_data >> {r_valE[1:0], 3'b000};

  always_comb begin
    case (r_size)
      SZ_BYTE: load_value = r_unsigned ? {{(ADDR_W-8){1'b0}}, lane[7:0]}
                                       : {{(ADDR_W-8){lane[7]}}, lane[7:0]};
      SZ_HALF: load_value = r_unsigned ? {{(ADDR_W-16){1'b0}}, lane[15:0]}
                                       : {{(ADDR_W-16){lane[15]}}, lane[15:0]};
      default: load_value = bus.dresp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dstE        <= '0;
      r_dstM        <= '0;
      r_valE        <= '0;
      r_valA        <= '0;
      r_pc          <= '0;
      r_valM        <= '0;
      r_stat        <= '0;
      r_size        <= SZ_WORD;
      r_load        <= 1'b0;
      r_store       <= 1'b0;
      r_unsigned    <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      if (capture) begin
        r_dstE     <= bus.in_dstE;
        r_dstM     <= bus.in_dstM;
        r_valE     <= bus.in_valE;
        r_valA     <= bus.in_valA;
        r_pc       <= bus.in_pc;
        r_valM     <= '0;
        r_stat     <= dec_stat;
        r_size     <= dec_size;
        r_load     <= dec_load;
        r_store    <= dec_store;
        r_unsigned <= dec_unsigned;
      end else if (complete && r_load) begin
        r_valM <= load_value;
      end
      // flush during a bus transaction is remembered until the response arrives
      if ((state == S_REQ) || (state == S_WAIT))
        flush_pending <= complete ? 1'b0 : (flush_pending || flush);
      else
        flush_pending <= 1'b0;
    end
  end

  always_comb begin
    bus.dreq_addr = {r_valE[ADDR_W-1:2], 2'b00};
    case (r_size)
      SZ_BYTE: begin
        bus.dreq_strobe = 4'b0001 << r_valE[1:0];
        bus.dreq_data   = {4{r_valA[7:0]}};
      end
      SZ_HALF: begin
        bus.dreq_strobe = 4'b0011 << r_valE[1:0];
        bus.dreq_data   = {2{r_valA[15:0]}};
      end
      default: begin
        bus.dreq_strobe = 4'hF;
        bus.dreq_data   = r_valA;
      end
    endcase
    if (!r_store) bus.dreq_strobe = 4'h0;
  end

  assign bus.out_dstE = r_dstE;
  assign bus.out_dstM = r_dstM;
  assign bus.out_valE = r_valE;
  assign bus.out_pc   = r_pc;
  assign bus.out_valM = r_valM;
  assign bus.out_stat = r_stat;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, load/store bus timing, faults, flush, stall and back-to-back accept.
module tb_mem_access_stage;

  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_ADDIU = 6'h09;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  mem_access_stage_if #(.ADDR_W(32)) bus ();

  mem_access_stage #(
    .OP_LW  (OP_LW),
    .OP_SW  (OP_SW),
    .ADDR_W (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] vale, input logic [31:0] vala,
                      input logic [1:0] stat, input logic [4:0] dste, input logic [4:0] dstm,
                      input logic [31:0] pc);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_funct  = 6'h21;
    bus.in_valE   = vale;
    bus.in_valA   = vala;
    bus.in_stat   = stat;
    bus.in_dstE   = dste;
    bus.in_dstM   = dstm;
    bus.in_pc     = pc;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_opcode = '0; bus.in_funct = '0; bus.in_dstE = '0; bus.in_dstM = '0;
    bus.in_valE = '0; bus.in_valA = '0; bus.in_pc = '0; bus.in_stat = '0;
    bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0; bus.dresp_data = '0;
    bus.out_ready = 1'b1;

    tick(); tick();
    check("rst_in_ready",  bus.in_ready,    0);
    check("rst_out_valid", bus.out_valid,   0);
    check("rst_dreq",      bus.dreq_valid,  0);
    check("rst_valE",      bus.out_valE,    0);
    check("rst_strobe",    bus.dreq_strobe, 0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);

    // ADDIU pass-through, one cycle
    send(OP_ADDIU, 32'h5, 32'h0, 2'd0, 5'd7, 5'd0, 32'h400);
    tick();
    bus.in_valid = 1'b0;
    check("alu_valid", bus.out_valid, 1);
    check("alu_valE",  bus.out_valE,  32'h5);
    check("alu_valM",  bus.out_valM,  0);
    check("alu_dstE",  bus.out_dstE,  7);
    check("alu_pc",    bus.out_pc,    32'h400);
    check("alu_dreq",  bus.dreq_valid, 0);
    tick();
    check("alu_drain", bus.out_valid, 0);

    // LW: addr_ok after 2 REQ cycles, data_ok 3 cycles later
    send(OP_LW, 32'h80001000, 32'h0, 2'd0, 5'd0, 5'd3, 32'h404);
    tick();
    bus.in_valid = 1'b0;
    check("lw_req1",    bus.dreq_valid,  1);
    check("lw_addr",    bus.dreq_addr,   32'h80001000);
    check("lw_strobe",  bus.dreq_strobe, 0);
    check("lw_inrdy",   bus.in_ready,    0);
    tick();
    check("lw_req2",    bus.dreq_valid,  1);
    bus.dresp_addr_ok = 1'b1;
    tick();
    bus.dresp_addr_ok = 1'b0;
    check("lw_wait_dreq", bus.dreq_valid, 0);
    tick();
    tick();
    check("lw_wait_ov", bus.out_valid, 0);
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data = 32'hDEADBEEF;
    tick();
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data = 32'h0;
    check("lw_valid",   bus.out_valid, 1);
    check("lw_valM",    bus.out_valM,  32'hDEADBEEF);
    check("lw_stat",    bus.out_stat,  0);
    check("lw_dstM",    bus.out_dstM,  3);
    tick();

    // SW: addr_ok and data_ok together
    send(OP_SW, 32'h80001004, 32'h12345678, 2'd0, 5'd0, 5'd0, 32'h408);
    tick();
    bus.in_valid = 1'b0;
    check("sw_req",     bus.dreq_valid,  1);
    check("sw_strobe",  bus.dreq_strobe, 4'hF);
    check("sw_data",    bus.dreq_data,   32'h12345678);
    check("sw_addr",    bus.dreq_addr,   32'h80001004);
    bus.dresp_addr_ok = 1'b1;
    bus.dresp_data_ok = 1'b1;
    tick();
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    check("sw_valid",   bus.out_valid, 1);
    check("sw_valM",    bus.out_valM,  0);
    check("sw_dreq",    bus.dreq_valid, 0);
    tick();

    // misaligned word load/store fault without bus access
    send(OP_LW, 32'h80001002, 32'h0, 2'd0, 5'd0, 5'd4, 32'h40c);
    tick();
    bus.in_valid = 1'b0;
    check("adel_dreq",  bus.dreq_valid, 0);
    check("adel_valid", bus.out_valid,  1);
    check("adel_stat",  bus.out_stat,   1);
    check("adel_valM",  bus.out_valM,   0);
    tick();
    send(OP_SW, 32'h80001002, 32'hAAAA5555, 2'd0, 5'd0, 5'd0, 32'h410);
    tick();
    bus.in_valid = 1'b0;
    check("ades_dreq",  bus.dreq_valid, 0);
    check("ades_stat",  bus.out_stat,   2);
    tick();

    // upstream fault on a load: forwarded, no bus access
    send(OP_LW, 32'h80001000, 32'h0, 2'd3, 5'd0, 5'd5, 32'h414);
    tick();
    bus.in_valid = 1'b0;
    check("fault_dreq", bus.dreq_valid, 0);
    check("fault_stat", bus.out_stat,   3);
    check("fault_valM", bus.out_valM,   0);
    tick();

    // flush in WAIT: response still consumed, no out_valid
    send(OP_LW, 32'h80002000, 32'h0, 2'd0, 5'd0, 5'd6, 32'h418);
    tick();
    bus.in_valid = 1'b0;
    bus.dresp_addr_ok = 1'b1;
    tick();
    bus.dresp_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_inrdy_wait", bus.in_ready, 0);
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data = 32'hCAFEF00D;
    tick();
    bus.dresp_data_ok = 1'b0;
    check("fl_out_valid", bus.out_valid, 0);
    check("fl_in_ready",  bus.in_ready,  1);
    check("fl_dreq",      bus.dreq_valid, 0);

    // flush and capture in the same cycle: nothing captured
    send(OP_ADDIU, 32'h77, 32'h0, 2'd0, 5'd1, 5'd0, 32'h41c);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flcap_valid", bus.out_valid, 0);

    // stall in DONE for 4 cycles, then back-to-back accept
    bus.out_ready = 1'b0;
    send(OP_ADDIU, 32'h11, 32'h0, 2'd0, 5'd2, 5'd0, 32'h420);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_valE",  bus.out_valE,  32'h11);
      check("stall_pc",    bus.out_pc,    32'h420);
      check("stall_inrdy", bus.in_ready,  0);
      tick();
    end
    bus.out_ready = 1'b1;
    send(OP_ADDIU, 32'h22, 32'h0, 2'd0, 5'd9, 5'd0, 32'h424);
    #1;
    check("b2b_inrdy", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_valE",  bus.out_valE,  32'h22);
    check("b2b_dstE",  bus.out_dstE,  9);

    // flush in DONE drops the bundle
    bus.out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    check("fldone_valid", bus.out_valid, 0);
    check("fldone_inrdy", bus.in_ready,  1);

    // byte load: lane select/sign-extend with the option, pass-through without
    send(6'h20, 32'h80001003, 32'h0, 2'd0, 5'd0, 5'd8, 32'h428);
    tick();
    bus.in_valid = 1'b0;
`ifdef MEM_BYTE_HALF_EN
    check("lb_req",    bus.dreq_valid,  1);
    check("lb_strobe", bus.dreq_strobe, 0);
    bus.dresp_addr_ok = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data = 32'h80123456;
    tick();
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    check("lb_valM",   bus.out_valM, 32'hFFFFFF80);
`else
    check("lb_dreq",   bus.dreq_valid, 0);
    check("lb_valid",  bus.out_valid,  1);
    check("lb_valM",   bus.out_valM,   0);
    check("lb_stat",   bus.out_stat,   0);
`endif
    tick();

    // reset abandons an in-flight request
    send(OP_LW, 32'h80003000, 32'h0, 2'd0, 5'd0, 5'd1, 32'h42c);
    tick();
    bus.in_valid = 1'b0;
    check("rr_req", bus.dreq_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rr_dreq",  bus.dreq_valid, 0);
    check("rr_inrdy", bus.in_ready,   1);
    check("rr_valE",  bus.out_valE,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
